lane_move_fsm: RTL
==================

Name: lane_move_fsm

Overview:
- Clocked, parametrised successor to the combinational 3-lane player-position FSM.
- Tracks the player's lane across NUM_LANES lanes, driven by left/right/start buttons.
- Sits between the debounced button inputs and the VGA sprite/collision logic.
- Adds rising-edge detection, a start/idle phase, a post-move cooldown, edge-of-track flags and a move strobe.

Parameters:
- NUM_LANES, 3: number of lanes; legal range >= 2.
- START_LANE, 1: lane index loaded at reset and clear; must be < NUM_LANES.
- COOLDOWN_CYCLES, 0: clocks after a move during which presses are ignored; 0 disables cooldown.
- LANE_W, $clog2(NUM_LANES): lane index width. Derived; do not override.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_left  in  1  debounced left button, synchronous to clk, level.
- btn_right  in  1  debounced right button, synchronous to clk, level.
- btn_start  in  1  debounced start button, synchronous to clk, level.
- clear  in  1  synchronous return to IDLE (game over / restart).
- lane  out  LANE_W  current lane index, 0 = leftmost.
- lane_onehot  out  NUM_LANES  one-hot copy of lane; bit i set when lane == i.
- started  out  1  high while in ACTIVE or COOLDOWN.
- moved  out  1  one-cycle strobe, high the cycle after a lane change.
- at_left  out  1  lane == 0.
- at_right  out  1  lane == NUM_LANES-1.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE, lane = START_LANE, lane_onehot = 1<<START_LANE.
  - started = 0, moved = 0.
  - Previous-button registers = 0, cooldown counter = 0.
  - at_left/at_right are decoded from lane.
- Edge detect: a press is btn_x = 1 while prev_x = 0.
  - prev_x is registered every cycle in every state, including IDLE and COOLDOWN.
  - A held button therefore produces exactly one press.
- States:
  - IDLE -> ACTIVE on a start press. Direction presses are ignored in IDLE; lane holds START_LANE.
  - ACTIVE:
    - Left press alone: lane-1, unless at_left.
    - Right press alone: lane+1, unless at_right.
    - Left and right pressed in the same cycle: no move.
    - Start press in ACTIVE: ignored.
    - After a successful move: go to COOLDOWN if COOLDOWN_CYCLES > 0, else remain in ACTIVE.
  - COOLDOWN:
    - Counter loads COOLDOWN_CYCLES-1 on entry and decrements each cycle.
    - At 0, return to ACTIVE.
    - Presses during COOLDOWN are dropped, not queued.
    - A button still held when COOLDOWN ends does not move; a fresh edge is required.
- Latency: lane, lane_onehot, at_left/at_right and moved all update at the clock edge that samples the press; visible one cycle after the input rises.
- moved:
  - Asserted for exactly one cycle per actual lane change.
  - Not asserted for blocked moves at an edge, simultaneous presses, or ignored presses.
- clear (synchronous, highest priority after rst):
  - state = IDLE, lane = START_LANE, moved = 0, counter = 0.
  - Takes precedence over any same-cycle press.
  - prev_x registers still update.
- Width: lane arithmetic is done in LANE_W bits; saturating bounds make overflow impossible.
- Elaboration: fails (generate-time error) if NUM_LANES < 2 or START_LANE >= NUM_LANES.

Optional Feature:
- Macro: LANE_WRAP_EN.
- Defined: left press at lane 0 goes to lane NUM_LANES-1, and right press at NUM_LANES-1 goes to lane 0. Both count as moves (moved=1, cooldown applies). at_left/at_right remain pure position flags.
- Undefined: lane saturates at both ends, and a blocked press produces no moved strobe and no cooldown.

Test Plan:
- Defaults for all cases: NUM_LANES=3, START_LANE=1, COOLDOWN_CYCLES=0, macro off, unless stated.
- Reset then idle: btn_left pulse before start -> lane=1, started=0, moved never high. Then start pulse -> started=1 next cycle, lane still 1.
- Moves and saturation: after start, right press -> lane=2, moved one cycle, at_right=1. Right press again -> lane=2, moved=0. Three left presses -> lane 1, 0, 0; at_left=1.
- Hold and simultaneous presses: hold btn_right for 10 cycles -> exactly one move. Assert both buttons in the same cycle -> lane unchanged, moved=0.
- Cooldown (COOLDOWN_CYCLES=3): right press at cycle t -> lane=2. Left press at t+2 -> ignored. Fresh left press at t+4 -> lane=1.
- Clear and async reset: clear with a simultaneous left press in ACTIVE at lane 2 -> lane=1, started=0. rst asserted mid-cycle -> outputs return to reset values without waiting for clk.
- LANE_WRAP_EN defined, NUM_LANES=5, START_LANE=0: left press -> lane=4, moved=1. Right press -> lane=0.

Source files
------------

// File: rtl/lane_move_fsm.sv
// lane_move_fsm: clocked player-lane tracker across NUM_LANES lanes with button
// edge detection, an idle/start phase, an optional post-move cooldown, edge-of-track
// flags and a one-cycle move strobe.
// Optional feature macro: LANE_WRAP_EN (wrap from one end of the track to the other).
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   btn_left     debounced left button (level)
//   btn_right    debounced right button (level)
//   btn_start    debounced start button (level)
//   clear        synchronous return to IDLE
//   lane         current lane index, 0 = leftmost
//   lane_onehot  one-hot copy of lane
//   started      high in ACTIVE or COOLDOWN
//   moved        one-cycle strobe after each lane change
//   at_left      lane == 0
//   at_right     lane == NUM_LANES-1
module lane_move_fsm #(
    parameter int NUM_LANES       = 3,
    parameter int START_LANE      = 1,
    parameter int COOLDOWN_CYCLES = 0,
    parameter int LANE_W          = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_start,
    input  logic                 clear,
    output logic [LANE_W-1:0]    lane,
    output logic [NUM_LANES-1:0] lane_onehot,
    output logic                 started,
    output logic                 moved,
    output logic                 at_left,
    output logic                 at_right
);
    generate
        if (NUM_LANES < 2 || START_LANE >= NUM_LANES) begin : g_bad_params
            $error("lane_move_fsm: need NUM_LANES >= 2 and START_LANE < NUM_LANES");
        end
    endgenerate

    localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CD_LOAD = CNT_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
    localparam logic [LANE_W-1:0] LAST    = LANE_W'(NUM_LANES - 1);
    localparam logic [LANE_W-1:0] START   = LANE_W'(START_LANE);

    typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;

    state_t            state, state_n;
    logic [LANE_W-1:0] lane_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              moved_n;
    logic              prev_left, prev_right, prev_start;
    logic              press_left, press_right, press_start;
    logic              go_left, go_right;

    assign press_left  = btn_left & ~prev_left;
    assign press_right = btn_right & ~prev_right;
    assign press_start = btn_start & ~prev_start;
    // simultaneous left and right presses cancel each other
    assign go_left     = press_left & ~press_right;
    assign go_right    = press_right & ~press_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lane       <= START;
            cnt        <= '0;
            moved      <= 1'b0;
            prev_left  <= 1'b0;
            prev_right <= 1'b0;
            prev_start <= 1'b0;
        end else begin
            state      <= state_n;
            lane       <= lane_n;
            cnt        <= cnt_n;
            moved      <= moved_n;
            prev_left  <= btn_left;
            prev_right <= btn_right;
            prev_start <= btn_start;
        end
    end

    always_comb begin
        state_n = state;
        lane_n  = lane;
        cnt_n   = cnt;
        moved_n = 1'b0;
        case (state)
            IDLE: if (press_start) state_n = ACTIVE;
            ACTIVE: begin
`ifdef LANE_WRAP_EN
                if (go_left) begin
                    lane_n  = at_left ? LAST : lane - 1'b1;
                    moved_n = 1'b1;
                end else if (go_right) begin
                    lane_n  = at_right ? '0 : lane + 1'b1;
                    moved_n = 1'b1;
                end
`else
                if (go_left && !at_left) begin
                    lane_n  = lane - 1'b1;
                    moved_n = 1'b1;
                end else if (go_right && !at_right) begin
                    lane_n  = lane + 1'b1;
                    moved_n = 1'b1;
                end
`endif
                if (moved_n && COOLDOWN_CYCLES > 0) begin
                    state_n = COOLDOWN;
                    cnt_n   = CD_LOAD;
                end
            end
            COOLDOWN: begin
                if (cnt == '0) state_n = ACTIVE;
                else cnt_n = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (clear) begin
            state_n = IDLE;
            lane_n  = START;
            cnt_n   = '0;
            moved_n = 1'b0;
        end
    end

    assign started  = (state != IDLE);
    assign at_left  = (lane == '0);
    assign at_right = (lane == LAST);

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_onehot
            assign lane_onehot[i] = (lane == LANE_W'(i));
        end
    endgenerate
endmodule
